risc_result_writer: RTL and testbench

Write-side companion to the RISC test harness. It captures each result the s3rb core produces (one per done assertion) as {cb, aluout} into an internal result buffer. On request, it streams the buffer out over a valid/ready interface so the results can be written to an output memory or a checker. It sits directly on the s3rb outputs, on the same clock as the harness.

---
 rtl/risc_result_writer.sv | 178 +++++++++++++++++
 tb/tb_risc_result_writer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/risc_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : risc_result_writer
// Captures one {cb, aluout} result per s3rb done assertion into a small
//            buffer and streams the buffer out over valid/ready on request.
// Revision : 1.0
// ============================================================================
module risc_result_writer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done,
    input  logic [DATA_W-1:0] aluout,
    input  logic              cb,
    input  logic              dump_start,
    input  logic              clear,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W:0]   out_data,
    output logic              out_last,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              dump_done,
    output logic [DROP_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'd0,
        ST_FULL    = 2'd1,
        ST_DUMP    = 2'd2,
        ST_FIN     = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   C_DEPTH    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   C_ONE      = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   C_TWO      = (ADDR_W+1)'(2);
    localparam logic [DROP_W-1:0] C_DROP_MAX = '1;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic                done_q;
    logic                out_valid_q, out_valid_d;
    logic                out_last_q, out_last_d;
    logic                full_q, full_d;
    logic                dump_done_q, dump_done_d;
    logic [DROP_W-1:0]   drop_cnt_q, drop_cnt_d;

    logic [DATA_W:0]     mem [DEPTH];

    logic w_capture;
    logic w_wr_en;
    logic w_drop;
    logic w_xfer;

    assign w_capture = done & ~done_q;
    assign w_xfer    = out_valid_q & out_ready;

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        dump_done_d = dump_done_q;
        drop_cnt_d  = drop_cnt_q;
        w_wr_en     = 1'b0;
        w_drop      = 1'b0;

        if (clear) begin
            state_d     = ST_CAPTURE;
            count_d     = '0;
            rd_ptr_d    = '0;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            dump_done_d = 1'b0;
            drop_cnt_d  = '0;
        end else begin
            case (state_q)
                ST_CAPTURE, ST_FULL: begin
                    if (w_capture) begin
                        if (state_q == ST_CAPTURE) begin
                            w_wr_en = 1'b1;
                            count_d = count_q + C_ONE;
                        end else begin
                            w_drop = 1'b1;
                        end
                    end
                    // A same-cycle capture is already reflected in count_d
                    if (dump_start) begin
                        if (count_d == '0) begin
                            state_d     = ST_FIN;
                            dump_done_d = 1'b1;
                        end else begin
                            state_d     = ST_DUMP;
                            rd_ptr_d    = '0;
                            out_valid_d = 1'b1;
                            out_last_d  = (count_d == C_ONE);
                        end
                    end else if (count_d == C_DEPTH) begin
                        state_d = ST_FULL;
                    end
                end
                ST_DUMP: begin
                    w_drop = w_capture;
                    if (w_xfer) begin
                        if (out_last_q) begin
                            state_d     = ST_FIN;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                            dump_done_d = 1'b1;
                        end else begin
                            rd_ptr_d   = rd_ptr_q + 1'b1;
                            out_last_d = (({1'b0, rd_ptr_q} + C_TWO) == count_q);
                        end
                    end
                end
                ST_FIN: begin
                    w_drop = w_capture;
                end
                default: begin
                    state_d = ST_CAPTURE;
                end
            endcase

            if (w_drop && (drop_cnt_q != C_DROP_MAX)) begin
                drop_cnt_d = drop_cnt_q + 1'b1;
            end
        end

        full_d = (count_d == C_DEPTH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_CAPTURE;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            full_q      <= 1'b0;
            dump_done_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            done_q      <= done;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            full_q      <= full_d;
            dump_done_q <= dump_done_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    // Buffer contents survive reset; only the bookkeeping is cleared
    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            mem[count_q[ADDR_W-1:0]] <= {cb, aluout};
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = mem[rd_ptr_q];
    assign out_last  = out_last_q;
    assign count     = count_q;
    assign full      = full_q;
    assign dump_done = dump_done_q;
    assign drop_cnt  = drop_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_risc_result_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_risc_result_writer
// Randomized and directed bench for risc_result_writer with a queue-based
//            reference model and a decoupled stream monitor.
// Revision : 1.0
// ============================================================================
module tb_risc_result_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        done = 1'b0;
    logic [15:0] aluout = '0;
    logic        cb = 1'b0;
    logic        dump_start = 1'b0;
    logic        clear = 1'b0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [16:0] out_data;
    logic        out_last;
    logic [3:0]  count;
    logic        full;
    logic        dump_done;
    logic [7:0]  drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stored results, drop total, and a coarse mode
    // (0 = accepting results, 1 = streaming, 2 = stream finished).
    logic [16:0] m_buf[$];
    logic [17:0] exp_q[$];
    int          m_drops = 0;
    int          m_mode  = 0;
    bit          m_prev_done = 1'b0;

    always #5 clk = ~clk;

    risc_result_writer dut (
        .clk        (clk),
        .rst        (rst),
        .done       (done),
        .aluout     (aluout),
        .cb         (cb),
        .dump_start (dump_start),
        .clear      (clear),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .count      (count),
        .full       (full),
        .dump_done  (dump_done),
        .drop_cnt   (drop_cnt)
    );

    task automatic model_step(input bit r, input bit d, input logic [15:0] a,
                              input bit c, input bit ds, input bit clr);
        if (r) begin
            m_buf.delete();
            exp_q.delete();
            m_drops = 0;
            m_mode  = 0;
            m_prev_done = 1'b0;
            return;
        end
        if (clr) begin
            m_buf.delete();
            exp_q.delete();
            m_drops = 0;
            m_mode  = 0;
        end else begin
            if (m_mode == 1 && exp_q.size() == 0) m_mode = 2;
            if (d && !m_prev_done) begin
                if (m_mode == 0 && m_buf.size() < 8) m_buf.push_back({c, a});
                else if (m_drops < 255) m_drops++;
            end
            if (ds && m_mode == 0) begin
                if (m_buf.size() == 0) m_mode = 2;
                else begin
                    m_mode = 1;
                    foreach (m_buf[i]) exp_q.push_back({(i == m_buf.size() - 1), m_buf[i]});
                end
            end
        end
        m_prev_done = d;
    endtask

    task automatic check_state();
        logic [14:0] got, expv;
        got  = {count, full, dump_done, out_valid, drop_cnt};
        expv = {4'(m_buf.size()), (m_buf.size() == 8), (m_mode == 2), (m_mode == 1), 8'(m_drops)};
        n_tests++;
        if (got !== expv) begin
            n_fail++;
            $display("FAIL state @%0t: got cnt=%0d full=%b dump_done=%b valid=%b drop=%0d, expected cnt=%0d full=%b dump_done=%b valid=%b drop=%0d",
                     $time, got[14:11], got[10], got[9], got[8], got[7:0],
                     expv[14:11], expv[10], expv[9], expv[8], expv[7:0]);
        end
    endtask

    task automatic cycle(input bit r, input bit d, input logic [15:0] a, input bit c,
                         input bit ds, input bit clr, input bit rdy);
        @(negedge clk);
        rst = r; done = d; aluout = a; cb = c;
        dump_start = ds; clear = clr; out_ready = rdy;
        @(posedge clk);
        #1;
        model_step(r, d, a, c, ds, clr);
        check_state();
    endtask

    task automatic pulse(input logic [15:0] a, input bit c);
        cycle(0, 1, a, c, 0, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
    endtask

    task automatic run_dump(input logic [15:0] pat, input int plen);
        int k = 0;
        cycle(0, 0, 16'h0, 0, 1, 0, 1);
        while (m_mode == 1 && k < 200) begin
            cycle(0, 0, 16'h0, 0, 0, 0, pat[k % plen]);
            k++;
        end
        n_tests++;
        if (m_mode == 1) begin
            n_fail++;
            $display("FAIL dump_timeout: stream still open after %0d cycles, expected finished", k);
        end
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
    endtask

    // Monitor: checks every transferred beat against the model's queue and
    // that a stalled beat stays unchanged until it is accepted.
    initial begin
        logic [16:0] held;
        bit          holding;
        logic [17:0] e;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            #4;
            if (holding && out_valid === 1'b1) begin
                n_tests++;
                if (out_data !== held) begin
                    n_fail++;
                    $display("FAIL stall_stable: out_data=%h, expected held %h", out_data, held);
                end
            end
            holding = 1'b0;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL beat_unexpected: out_data=%h, expected no beat", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_last, out_data} !== e) begin
                        n_fail++;
                        $display("FAIL beat: got last=%b data=%h, expected last=%b data=%h",
                                 out_last, out_data, e[17], e[16:0]);
                    end
                end
            end else if (out_valid === 1'b1) begin
                holding = (rst === 1'b0) && (clear === 1'b0);
                held    = out_data;
            end
        end
    end

    initial begin
        cycle(1, 0, 16'h0, 0, 0, 0, 0);
        cycle(1, 0, 16'h0, 0, 0, 0, 0);

        // Three captured results, then streamed with an irregular ready
        pulse(16'h0005, 0);
        pulse(16'hFFFF, 1);
        pulse(16'h1234, 0);
        run_dump(16'b101001, 6);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        // Level-high done stores a single entry
        for (int i = 0; i < 5; i++) cycle(0, 1, 16'(16'h0A00 + i), i[0], 0, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        // Overfill, then a full-speed dump
        for (int i = 1; i <= 10; i++) pulse(16'(i), 0);
        run_dump(16'h0001, 1);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        // Empty dump, clear, and a fresh capture lands at index 0
        cycle(0, 0, 16'h0, 0, 1, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);
        pulse(16'hABCD, 1);
        run_dump(16'h0001, 1);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        // Reset mid-stream, then clear beats dump_start
        for (int i = 0; i < 5; i++) pulse(16'(16'h0100 + i), 0);
        cycle(0, 0, 16'h0, 0, 1, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
        cycle(1, 0, 16'h0, 0, 0, 0, 0);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);
        pulse(16'h0042, 0);
        pulse(16'h0043, 1);
        cycle(0, 1, 16'h0044, 0, 1, 1, 1);
        cycle(0, 0, 16'h0, 0, 0, 0, 1);

        // Drop counter saturation
        cycle(0, 0, 16'h0, 0, 0, 1, 1);
        for (int i = 0; i < 270; i++) pulse(16'(i), 1);
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        // Randomized traffic including capture/dump_start collisions
        for (int i = 0; i < 1500; i++) begin
            cycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1), 16'($urandom),
                  $urandom_range(0, 1), ($urandom_range(0, 11) == 0),
                  ($urandom_range(0, 39) == 0), $urandom_range(0, 1));
        end
        cycle(0, 0, 16'h0, 0, 0, 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
